mem_ctrl_host: RTL



---
 rtl/mem_ctrl_pkg.sv | 25 ++
 rtl/bank_row_table.sv | 45 ++++
 rtl/mem_ctrl_host.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared FSM state type, DDR4 command codes for A[16:14] and wait-counter width
// for the host-side memory command initiator.
package mem_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ACT     = 4'd1,
        TRCD_W  = 4'd2,
        CMD     = 4'd3,
        RD_W    = 4'd4,
        RD_DATA = 4'd5,
        WR_W    = 4'd6,
        WR_DATA = 4'd7,
        TWR_W   = 4'd8,
        PRE     = 4'd9,
        TRP_W   = 4'd10
    } state_t;

    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;

    localparam int unsigned CNT_W = 6;

endpackage

// File: rtl/bank_row_table.sv
// Per-bank open flag and open row, used by the open-page policy
// (present only when MEM_CTRL_OPEN_PAGE_EN is defined).
module bank_row_table #(
    parameter int BANKW = 4,
    parameter int ROWW  = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BANKW-1:0] lookup_bank,
    input  logic [ROWW-1:0]  lookup_row,
    output logic             hit,
    output logic             is_open,
    input  logic             set_en,
    input  logic [BANKW-1:0] set_bank,
    input  logic [ROWW-1:0]  set_row,
    input  logic             clr_en,
    input  logic [BANKW-1:0] clr_bank
);

    localparam int unsigned NB = 1 << BANKW;

    logic [NB-1:0]   open_flag;
    logic [ROWW-1:0] rows [NB];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            open_flag <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                rows[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                open_flag[clr_bank] <= 1'b0;
            end
            if (set_en) begin
                open_flag[set_bank] <= 1'b1;
                rows[set_bank]      <= set_row;
            end
        end
    end

    assign is_open = open_flag[lookup_bank];
    assign hit     = is_open && (rows[lookup_bank] == lookup_row);

endmodule

// File: rtl/mem_ctrl_host.sv
// Host-side DDR4 command initiator: ACT -> RD/WR -> PRE sequencing with dq/dqs
// burst launch/capture. Define MEM_CTRL_OPEN_PAGE_EN for the open-page policy.
module mem_ctrl_host
    import mem_ctrl_pkg::*;
#(
    parameter int CHIPS        = 16,
    parameter int DEVICE_WIDTH = 4,
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int BL           = 8,
    parameter int TRCD         = 4,
    parameter int TCL          = 6,
    parameter int TCWL         = 5,
    parameter int TWR          = 4,
    parameter int TRP          = 4,
    parameter int DQWIDTH      = DEVICE_WIDTH * CHIPS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [BGWIDTH-1:0]      req_bg,
    input  logic [BAWIDTH-1:0]      req_ba,
    input  logic [ADDRWIDTH-1:0]    req_row,
    input  logic [COLWIDTH-1:0]     req_col,
    input  logic [BL*DQWIDTH-1:0]   req_wdata,
    output logic                    rsp_valid,
    output logic [BL*DQWIDTH-1:0]   rsp_rdata,
    input  logic                    stall,
    output logic                    cke,
    output logic                    cs_n,
    output logic                    act_n,
    output logic [ADDRWIDTH-1:0]    A,
    output logic [BGWIDTH-1:0]      bg,
    output logic [BAWIDTH-1:0]      ba,
    output logic [DQWIDTH-1:0]      dq_o,
    output logic                    dq_oe,
    input  logic [DQWIDTH-1:0]      dq_i,
    output logic [CHIPS-1:0]        dqs_t_o,
    output logic [CHIPS-1:0]        dqs_c_o,
    output logic                    dqs_oe
);

    localparam int DW = BL * DQWIDTH;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       beat;
    logic                   init_done;
    logic                   wr_r;
    logic [BGWIDTH-1:0]     bg_r;
    logic [BAWIDTH-1:0]     ba_r;
    logic [ADDRWIDTH-1:0]   row_r;
    logic [COLWIDTH-1:0]    col_r;
    logic [DW-1:0]          data_sh;
    logic [ADDRWIDTH-1:0]   a_last;
    logic                   issue;
    logic                   is_act;
    logic [ADDRWIDTH-1:0]   cmd_a;

`ifdef MEM_CTRL_OPEN_PAGE_EN
    logic hit;
    logic is_open;

    bank_row_table #(
        .BANKW (BGWIDTH + BAWIDTH),
        .ROWW  (ADDRWIDTH)
    ) u_bank_row_table (
        .clk         (clk),
        .reset_n     (reset_n),
        .lookup_bank ({req_bg, req_ba}),
        .lookup_row  (req_row),
        .hit         (hit),
        .is_open     (is_open),
        .set_en      (state == ACT && !stall),
        .set_bank    ({bg_r, ba_r}),
        .set_row     (row_r),
        .clr_en      (state == PRE && !stall),
        .clr_bank    ({bg_r, ba_r})
    );
`endif

    // Commands are decoded from state so a stall turns them into deselect the same cycle.
    always_comb begin
        issue  = 1'b0;
        is_act = 1'b0;
        cmd_a  = a_last;
        case (state)
            ACT: if (!stall) begin
                issue  = 1'b1;
                is_act = 1'b1;
                cmd_a  = row_r;
            end
            CMD: if (!stall) begin
                issue                 = 1'b1;
                cmd_a                 = '0;
                cmd_a[COLWIDTH-1:0]   = col_r;
                cmd_a[16:14]          = wr_r ? CMD_WR : CMD_RD;
                cmd_a[10]             = 1'b0;
            end
            PRE: if (!stall) begin
                issue        = 1'b1;
                cmd_a        = '0;
                cmd_a[16:14] = CMD_PRE;
            end
            default: ;
        endcase
    end

    assign cs_n      = ~issue;
    assign act_n     = ~is_act;
    assign A         = cmd_a;
    assign bg        = bg_r;
    assign ba        = ba_r;
    assign req_ready = init_done && (state == IDLE);
    assign dq_oe     = (state == WR_DATA);
    assign dqs_oe    = dq_oe;
    assign dq_o      = dq_oe ? data_sh[DQWIDTH-1:0] : '0;
    assign dqs_t_o   = {CHIPS{dq_oe & ~beat[0]}};
    assign dqs_c_o   = ~dqs_t_o;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            beat      <= '0;
            cke       <= 1'b0;
            init_done <= 1'b0;
            wr_r      <= 1'b0;
            bg_r      <= '0;
            ba_r      <= '0;
            row_r     <= '0;
            col_r     <= '0;
            data_sh   <= '0;
            a_last    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            cke       <= 1'b1;
            init_done <= cke;
            rsp_valid <= 1'b0;
            a_last    <= cmd_a;
            case (state)
                IDLE: if (req_valid && req_ready) begin
                    wr_r    <= req_write;
                    bg_r    <= req_bg;
                    ba_r    <= req_ba;
                    row_r   <= req_row;
                    col_r   <= req_col;
                    data_sh <= req_wdata;
`ifdef MEM_CTRL_OPEN_PAGE_EN
                    if (hit)          state <= CMD;
                    else if (is_open) state <= PRE;
                    else              state <= ACT;
`else
                    state   <= ACT;
`endif
                end
                ACT: if (!stall) begin
                    if (TRCD == 1) begin
                        state <= CMD;
                    end else begin
                        cnt   <= CNT_W'(TRCD - 1);
                        state <= TRCD_W;
                    end
                end
                TRCD_W: begin
                    if (cnt == CNT_W'(1)) state <= CMD;
                    else                  cnt   <= cnt - 1'b1;
                end
                CMD: if (!stall) begin
                    beat <= '0;
                    if (wr_r) begin
                        if (TCWL == 1) begin
                            state <= WR_DATA;
                        end else begin
                            cnt   <= CNT_W'(TCWL - 1);
                            state <= WR_W;
                        end
                    end else begin
                        if (TCL == 1) begin
                            state <= RD_DATA;
                        end else begin
                            cnt   <= CNT_W'(TCL - 1);
                            state <= RD_W;
                        end
                    end
                end
                RD_W: begin
                    if (cnt == CNT_W'(1)) state <= RD_DATA;
                    else                  cnt   <= cnt - 1'b1;
                end
                // Beats shift in at the top so beat 0 ends up in the LSBs.
                RD_DATA: begin
                    data_sh <= {dq_i, data_sh[DW-1:DQWIDTH]};
                    beat    <= beat + 1'b1;
                    if (beat == CNT_W'(BL - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= {dq_i, data_sh[DW-1:DQWIDTH]};
`ifdef MEM_CTRL_OPEN_PAGE_EN
                        state     <= IDLE;
`else
                        state     <= PRE;
`endif
                    end
                end
                WR_W: begin
                    if (cnt == CNT_W'(1)) state <= WR_DATA;
                    else                  cnt   <= cnt - 1'b1;
                end
                WR_DATA: begin
                    data_sh <= data_sh >> DQWIDTH;
                    beat    <= beat + 1'b1;
                    if (beat == CNT_W'(BL - 1)) begin
                        cnt   <= CNT_W'(TWR);
                        state <= TWR_W;
                    end
                end
                TWR_W: begin
                    if (cnt == CNT_W'(1)) begin
`ifdef MEM_CTRL_OPEN_PAGE_EN
                        state <= IDLE;
`else
                        state <= PRE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PRE: if (!stall) begin
                    cnt   <= CNT_W'(TRP);
                    state <= TRP_W;
                end
                // Open-page only precharges on a row miss, so TRP leads straight to ACT.
                TRP_W: begin
                    if (cnt == CNT_W'(1)) begin
`ifdef MEM_CTRL_OPEN_PAGE_EN
                        state <= ACT;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
